// File: rtl/pw_accum_pingpong_buffer_if.sv
// Slice-write and pixel-readout signals of the pointwise accumulation ping-pong buffer.
interface pw_accum_pingpong_buffer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OCP        = 8
);
  logic                      wr_en;
  logic [DATA_WIDTH*OCP-1:0] wr_data;
  logic [7:0]                wr_ic_sel;
  logic [7:0]                wr_oc_sel;
  logic                      pixel_done;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH*OCP-1:0] out_data;
  logic [7:0]                out_group;
  logic                      out_last;
  logic                      frame_done;
  logic                      stall;
  logic                      overflow;

  modport master (
    output wr_en, wr_data, wr_ic_sel, wr_oc_sel, pixel_done, out_ready,
    input  out_valid, out_data, out_group, out_last, frame_done, stall, overflow
  );

  modport slave (
    input  wr_en, wr_data, wr_ic_sel, wr_oc_sel, pixel_done, out_ready,
    output out_valid, out_data, out_group, out_last, frame_done, stall, overflow
  );
endinterface

// File: rtl/pw_accum_pingpong_buffer.sv
// Accumulates pointwise-conv slices across input groups into a two-bank pixel
// buffer and streams each finished pixel out one output-channel group per beat.
module pw_accum_pingpong_buffer #(
  parameter int unsigned DATA_WIDTH             = 16,
  parameter int unsigned OUTCHANNEL_PARALLELISM = 8,
  parameter int unsigned MAX_GROUPS             = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 output_size,
  input  logic [7:0]                 input_channel,
  input  logic [7:0]                 output_channel,
  input  logic                       relu_en,
  pw_accum_pingpong_buffer_if.slave  bus
);
  localparam int unsigned OCP = OUTCHANNEL_PARALLELISM;
  localparam int unsigned LW  = DATA_WIDTH * OCP;
  localparam int unsigned GW  = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;

  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_state_e;

  logic [LW-1:0] bank_q [2][MAX_GROUPS];

  rd_state_e     state_q, state_d;
  logic          wb_q, wb_d, rb_q, rb_d;
  logic [1:0]    full_q, full_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [LW-1:0] out_data_q, out_data_d;
  logic [7:0]    out_group_q, out_group_d;
  logic          out_last_q, out_last_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   pix_cnt_q, pix_cnt_d;

  logic [8:0]    grp_sum, ngrp;
  logic [15:0]   frame_px;
  logic [7:0]    wr_grp;
  logic          wr_hit;
  logic [LW-1:0] wr_cur, wr_next;
  logic          rd_free, other_full;

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [LW-1:0] relu(input logic [LW-1:0] v, input logic en);
    relu = v;
    if (en)
      for (int unsigned i = 0; i < OCP; i++)
        if (v[DATA_WIDTH*i + DATA_WIDTH-1]) relu[DATA_WIDTH*i +: DATA_WIDTH] = '0;
  endfunction

  always_comb begin
    grp_sum  = {1'b0, output_channel} + 9'(OCP - 1);
    ngrp     = grp_sum / 9'(OCP);
    if (ngrp == 9'd0)                  ngrp = 9'd1;
    else if (ngrp > 9'(MAX_GROUPS))    ngrp = 9'(MAX_GROUPS);
    frame_px = 16'(output_size) * 16'(output_size);
  end

  // Slice write: first input group overwrites, later ones saturate-accumulate.
  always_comb begin
    wr_grp  = bus.wr_oc_sel / 8'(OCP);
    wr_hit  = bus.wr_en && ({1'b0, wr_grp} < ngrp);
    wr_cur  = bank_q[wb_q][wr_grp[GW-1:0]];
    wr_next = bus.wr_data;
    if (bus.wr_ic_sel != '0)
      for (int unsigned i = 0; i < OCP; i++)
        wr_next[DATA_WIDTH*i +: DATA_WIDTH] = sat_add(wr_cur[DATA_WIDTH*i +: DATA_WIDTH],
                                                      bus.wr_data[DATA_WIDTH*i +: DATA_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (wr_hit) bank_q[wb_q][wr_grp[GW-1:0]] <= wr_next;
  end

  // A readout free lands before pixel_done is evaluated. A full write bank that
  // finds the other bank free again moves over to it, which also ends a stall.
  always_comb begin
    full_d     = full_q;
    wb_d       = wb_q;
    overflow_d = overflow_q;
    rd_free    = (state_q == RD_SEND) && bus.out_ready && out_last_q;
    if (rd_free) full_d[rb_q] = 1'b0;
    other_full = full_d[~wb_q];
    if (bus.pixel_done) begin
      if (full_q[wb_q] && other_full) overflow_d = 1'b1;
      full_d[wb_q] = 1'b1;
    end
    if ((bus.pixel_done || full_q[wb_q]) && !other_full) wb_d = ~wb_q;
  end

  always_comb begin
    state_d      = state_q;
    rb_d         = rb_q;
    grp_d        = grp_q;
    out_data_d   = out_data_q;
    out_group_d  = out_group_q;
    out_last_d   = out_last_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_d[rb_q]) begin
          state_d = RD_LOAD;
          grp_d   = '0;
        end
      end
      RD_LOAD: begin
        out_data_d  = relu(bank_q[rb_q][grp_q], relu_en);
        out_group_d = 8'(grp_q);
        out_last_d  = ({{(9-GW){1'b0}}, grp_q} == (ngrp - 9'd1));
        state_d     = RD_SEND;
      end
      RD_SEND: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d = RD_IDLE;
            rb_d    = ~rb_q;
            if (pix_cnt_q + 16'd1 == frame_px) begin
              pix_cnt_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              pix_cnt_d = pix_cnt_q + 16'd1;
            end
          end else begin
            grp_d   = grp_q + GW'(1);
            state_d = RD_LOAD;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      full_q       <= '0;
      grp_q        <= '0;
      out_data_q   <= '0;
      out_group_q  <= '0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      full_q       <= full_d;
      grp_q        <= grp_d;
      out_data_q   <= out_data_d;
      out_group_q  <= out_group_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  assign bus.out_valid  = (state_q == RD_SEND);
  assign bus.out_data   = out_data_q;
  assign bus.out_group  = out_group_q;
  assign bus.out_last   = out_last_q && (state_q == RD_SEND);
  assign bus.frame_done = frame_done_q;
  assign bus.stall      = full_q[0] && full_q[1];
  assign bus.overflow   = overflow_q;

  // Upstream only ever issues input-channel selects inside the layer.
  a_ic_sel_in_range: assert property (@(posedge clk) disable iff (rst)
    (bus.wr_en && input_channel != '0) |-> (bus.wr_ic_sel < input_channel));
endmodule

// File: tb/tb_pw_accum_pingpong_buffer.sv
// Scoreboard bench for pw_accum_pingpong_buffer: beats expected per pixel are
// queued when the pixel is written and checked as the DUT streams them out.
module tb_pw_accum_pingpong_buffer;
  localparam int DW  = 16;
  localparam int OCP = 8;
  localparam int MG  = 8;
  localparam int LW  = DW * OCP;

  typedef struct {
    logic [LW-1:0] data;
    logic [7:0]    grp;
    logic          last;
  } beat_t;

  logic       clk, rst;
  logic [7:0] output_size, input_channel, output_channel;
  logic       relu_en;

  pw_accum_pingpong_buffer_if #(.DATA_WIDTH(DW), .OCP(OCP)) bus_if ();

  pw_accum_pingpong_buffer #(
    .DATA_WIDTH(DW), .OUTCHANNEL_PARALLELISM(OCP), .MAX_GROUPS(MG)
  ) dut (
    .clk(clk), .rst(rst), .output_size(output_size), .input_channel(input_channel),
    .output_channel(output_channel), .relu_en(relu_en), .bus(bus_if)
  );

  int    total, bad, cyc, fd_count, fd_cyc, last_cyc, cfg_g;
  int    acc [MG][OCP];
  beat_t exp_q[$];
  beat_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Scoreboard consumer: a beat is accepted at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got group=%0d last=%0b, required no beat",
                   bus_if.out_group, bus_if.out_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus_if.out_data !== mon_e.data || bus_if.out_group !== mon_e.grp ||
              bus_if.out_last !== mon_e.last) begin
            bad++;
            $display("FAIL beat: got data=%h group=%0d last=%0b, required data=%h group=%0d last=%0b",
                     bus_if.out_data, bus_if.out_group, bus_if.out_last,
                     mon_e.data, mon_e.grp, mon_e.last);
          end
        end
        if (bus_if.out_last) last_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] fill(input logic [DW-1:0] v);
    for (int l = 0; l < OCP; l++) fill[DW*l +: DW] = v;
  endfunction

  function automatic logic [LW-1:0] rand_data();
    for (int l = 0; l < OCP; l++) rand_data[DW*l +: DW] = DW'($urandom);
  endfunction

  function automatic void model_write(input int ic, input int oc, input logic [LW-1:0] d);
    int g, v;
    logic signed [DW-1:0] lane;
    g = oc / OCP;
    if (g >= cfg_g) return;
    for (int l = 0; l < OCP; l++) begin
      lane = d[DW*l +: DW];
      v    = int'(lane);
      if (ic == 0) acc[g][l] = v;
      else begin
        v = acc[g][l] + v;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        acc[g][l] = v;
      end
    end
  endfunction

  function automatic void push_pixel(input logic relu);
    beat_t b;
    for (int g = 0; g < cfg_g; g++) begin
      for (int l = 0; l < OCP; l++)
        b.data[DW*l +: DW] = (relu && acc[g][l] < 0) ? '0 : DW'(acc[g][l]);
      b.grp  = 8'(g);
      b.last = (g == cfg_g - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic write_slice(input int ic, input int oc, input logic [LW-1:0] d,
                             input logic pd, input logic push);
    bus_if.wr_en      = 1'b1;
    bus_if.wr_ic_sel  = 8'(ic);
    bus_if.wr_oc_sel  = 8'(oc);
    bus_if.wr_data    = d;
    bus_if.pixel_done = pd;
    model_write(ic, oc, d);
    if (pd && push) push_pixel(relu_en);
    tick();
    bus_if.wr_en      = 1'b0;
    bus_if.pixel_done = 1'b0;
  endtask

  task automatic set_cfg(input int ic, input int oc);
    input_channel  = 8'(ic);
    output_channel = 8'(oc);
    cfg_g          = (oc + OCP - 1) / OCP;
    if (cfg_g == 0) cfg_g = 1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total += 7;
    if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", bus_if.out_valid); end
    if (bus_if.out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b required 0", bus_if.out_last); end
    if (bus_if.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b required 0", bus_if.frame_done); end
    if (bus_if.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b required 0", bus_if.overflow); end
    if (bus_if.stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b required 0", bus_if.stall); end
    if (bus_if.out_data !== '0) begin bad++; $display("FAIL rst_data: got %h required 0", bus_if.out_data); end
    if (bus_if.out_group !== 8'd0) begin bad++; $display("FAIL rst_group: got %0d required 0", bus_if.out_group); end
  endtask

  task automatic test_basic();
    set_cfg(8, 16);
    relu_en = 1'b0;
    bus_if.out_ready = 1'b1;
    write_slice(0, 0, fill(16'h0010), 1'b0, 1'b0);
    write_slice(0, 16, fill(16'h7777), 1'b0, 1'b0);   // group 2 >= G: dropped
    write_slice(0, 8, fill(16'h0010), 1'b1, 1'b1);
    total++;
    if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL latency_c1: got valid=%b required 0", bus_if.out_valid); end
    tick();
    total += 3;
    if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL latency_c2: got valid=%b required 1", bus_if.out_valid); end
    if (bus_if.out_group !== 8'd0) begin bad++; $display("FAIL first_group: got %0d required 0", bus_if.out_group); end
    if (bus_if.out_data !== fill(16'h0010)) begin bad++; $display("FAIL first_data: got %h required %h", bus_if.out_data, fill(16'h0010)); end
    wait_drain(50);
  endtask

  task automatic test_saturation();
    beat_t b;
    set_cfg(32, 8);
    bus_if.out_ready = 1'b1;
    b.grp = 8'd0;
    b.last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      relu_en = (k == 2);
      for (int s = 0; s < 4; s++)
        write_slice(8 * s, 0, fill(k == 0 ? 16'h4000 : 16'hC000), s == 3, 1'b0);
      b.data = (k == 0) ? fill(16'h7FFF) : (k == 1) ? fill(16'h8000) : fill(16'h0000);
      exp_q.push_back(b);
      wait_drain(50);
    end
    relu_en = 1'b0;
  endtask

  task automatic test_random_accum();
    bus_if.out_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      set_cfg(p == 0 ? 16 : 24, 16);
      relu_en = (p == 0);
      for (int s = 0; s < int'(input_channel) / OCP; s++)
        for (int g = 0; g < 2; g++)
          write_slice(8 * s, 8 * g, rand_data(),
                      (s == int'(input_channel) / OCP - 1) && g == 1, 1'b1);
      wait_drain(50);
    end
    relu_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    set_cfg(8, 24);
    bus_if.out_ready = 1'b1;
    for (int g = 0; g < 3; g++) write_slice(0, 8 * g, rand_data(), g == 2, 1'b1);
    n = 0;
    while (exp_q.size() != 2 && n < 20) begin tick(); n++; end
    bus_if.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus_if.out_valid) begin
        total++;
        if (bus_if.out_data !== exp_q[0].data || bus_if.out_group !== exp_q[0].grp ||
            bus_if.out_last !== exp_q[0].last) begin
          bad++;
          $display("FAIL hold_stable: got data=%h group=%0d last=%0b, required data=%h group=%0d last=%0b",
                   bus_if.out_data, bus_if.out_group, bus_if.out_last,
                   exp_q[0].data, exp_q[0].grp, exp_q[0].last);
        end
      end
    end
    total += 2;
    if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b required 1", bus_if.out_valid); end
    if (exp_q.size() != 2) begin bad++; $display("FAIL hold_pending: got %0d required 2", exp_q.size()); end
    bus_if.out_ready = 1'b1;
    wait_drain(50);
  endtask

  task automatic test_frame_done();
    do_reset();
    output_size = 8'd2;
    set_cfg(8, 8);
    bus_if.out_ready = 1'b1;
    fd_count = 0;
    for (int p = 0; p < 8; p++) begin
      write_slice(0, 0, rand_data(), 1'b1, 1'b1);
      wait_drain(50);
      if (p == 2) begin
        total++;
        if (fd_count != 0) begin bad++; $display("FAIL frame_early: got %0d pulses required 0", fd_count); end
      end
      if (p == 3) begin
        total += 2;
        if (fd_count != 1) begin bad++; $display("FAIL frame_once: got %0d pulses required 1", fd_count); end
        if (fd_cyc != last_cyc + 1) begin bad++; $display("FAIL frame_timing: got cycle %0d required %0d", fd_cyc, last_cyc + 1); end
      end
      if (p == 7) begin
        total++;
        if (fd_count != 2) begin bad++; $display("FAIL frame_wrap: got %0d pulses required 2", fd_count); end
      end
    end
    output_size = 8'd7;
  endtask

  task automatic test_stall_overflow();
    set_cfg(8, 8);
    bus_if.out_ready = 1'b0;
    write_slice(0, 0, rand_data(), 1'b1, 1'b1);
    write_slice(0, 0, rand_data(), 1'b1, 1'b0);
    total += 2;
    if (bus_if.stall !== 1'b1) begin bad++; $display("FAIL stall_set: got %b required 1", bus_if.stall); end
    if (bus_if.overflow !== 1'b0) begin bad++; $display("FAIL no_overflow_yet: got %b required 0", bus_if.overflow); end
    write_slice(0, 0, rand_data(), 1'b1, 1'b1);
    total++;
    if (bus_if.overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b required 1", bus_if.overflow); end
    bus_if.out_ready = 1'b1;
    wait_drain(50);
    total += 2;
    if (bus_if.overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b required 1", bus_if.overflow); end
    if (bus_if.stall !== 1'b0) begin bad++; $display("FAIL stall_clear: got %b required 0", bus_if.stall); end
  endtask

  task automatic test_reset_mid_readout();
    int n;
    set_cfg(8, 24);
    bus_if.out_ready = 1'b0;
    for (int g = 0; g < 3; g++) write_slice(0, 8 * g, rand_data(), g == 2, 1'b1);
    n = 0;
    while (!bus_if.out_valid && n < 20) begin tick(); n++; end
    total++;
    if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid_before_rst: got %b required 1", bus_if.out_valid); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    total += 3;
    if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got %b required 0", bus_if.out_valid); end
    if (bus_if.stall !== 1'b0) begin bad++; $display("FAIL async_rst_stall: got %b required 0", bus_if.stall); end
    if (bus_if.overflow !== 1'b0) begin bad++; $display("FAIL async_rst_overflow: got %b required 0", bus_if.overflow); end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    set_cfg(8, 8);
    bus_if.out_ready = 1'b1;
    write_slice(0, 0, rand_data(), 1'b1, 1'b1);
    wait_drain(50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; fd_count = 0; fd_cyc = 0; last_cyc = 0; cfg_g = 1;
    rst = 1'b1;
    output_size = 8'd7; input_channel = 8'd8; output_channel = 8'd8; relu_en = 1'b0;
    bus_if.wr_en = 1'b0; bus_if.wr_data = '0; bus_if.wr_ic_sel = '0; bus_if.wr_oc_sel = '0;
    bus_if.pixel_done = 1'b0; bus_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_random_accum();
    test_backpressure();
    test_frame_done();
    test_stall_overflow();
    test_reset_mid_readout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
